vram_rect_fill: RTL and testbench
=================================

# vram_rect_fill

Pixel-RAM writer: the producer side of the 640x480 12-bit framebuffer that the VGA scan controller reads. It accepts one rectangle-fill command through a valid/ready handshake and clips it to the visible area. It then writes one pixel per clock, in raster order, into the write port of the dual-port pixel RAM. It can optionally hold off until the start of vertical sync, so updates do not tear.

## Interface
- No parameters. Geometry comes from the shared package: H_ACTIVE=640, V_ACTIVE=480.
- clk  in  1  pixel clock, 25 MHz, same domain as the scan controller
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high exactly while in IDLE
- cmd_x0  in  10  left column
- cmd_y0  in  9  top row
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in lines
- cmd_color  in  12  fill colour, bbbb_gggg_rrrr
- cmd_sync  in  1  1 = wait for VS falling edge before filling
- vs  in  1  VS from the scan controller; low = vertical sync
- wr_row  out  9  pixel RAM row address
- wr_col  out  10  pixel RAM column address
- wr_data  out  12  pixel data
- wrn  out  1  write strobe, active-low
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse when a command completes

## Operation
- States:
  - IDLE: cmd_ready=1. Handshake (cmd_valid & cmd_ready) latches all cmd_* fields, then goes to CLIP.
  - CLIP: registers the clipped bounds, then moves to one of:
    - IDLE with done=1, if the rectangle is empty;
    - WAIT_VS, if sync=1;
    - FILL, otherwise.
  - WAIT_VS: goes to FILL on the first detected VS falling edge.
  - FILL: writes one pixel per cycle. The column runs x0..xe; at xe the column returns to x0 and the row increments. After the write at (ye, xe) the next state is IDLE with done=1.
- Edge detect: vs_q is vs registered, with reset value 1. A falling edge is vs_q & ~vs. Edges that occur outside WAIT_VS are ignored.
- Clipping uses 11-bit unsigned arithmetic:
  - xe = min(x0+w, 640) - 1
  - ye = min(y0+h, 480) - 1
  - Empty when w==0, h==0, x0>=640 or y0>=480.
- Write count is (xe-x0+1)*(ye-y0+1). No write ever falls outside 0..639 x 0..479.
- cmd_* inputs are don't-care outside the handshake cycle.
- wr_data is held at the latched colour throughout FILL.
- wr_row, wr_col and wr_data keep their last values when wrn=1.

## Timing
- Reset values: state IDLE, wrn=1, wr_row=0, wr_col=0, wr_data=0, done=0, busy=0, vs_q=1.
  - cmd_ready reads 1 during reset, but no handshake is honoured while rst=1.
- All outputs are registered, except cmd_ready and busy, which decode the state register.
- Let T be the handshake cycle:
  - CLIP occupies T+1.
  - Unsynced: the first write (wrn=0, row y0, col x0) is in T+2, and writes continue on consecutive cycles with no gaps.
  - Empty command: done=1 in T+2 and no writes.
  - Synced: with V the cycle in which the falling edge is detected, the first write is in V+1.
- If the last write is in cycle L, then in L+1: done=1, wrn=1, cmd_ready=1. The earliest next handshake is L+1.
- A 1x1 rectangle produces exactly one write cycle.
- Reset mid-operation: wrn goes to 1 asynchronously and any pending command is discarded. No done is produced.
- The pixel RAM write port never stalls. There is no backpressure input.

## Structure
- vga_pkg holds:
  - H_ACTIVE, V_ACTIVE;
  - ROW_W=9, COL_W=10, PIX_W=12;
  - the state encoding IDLE/CLIP/WAIT_VS/FILL.
- The scan controller uses the same geometry constants.
- Sub-module vram_rect_clip: combinational clip of (x0,y0,w,h) to (xe, ye, empty). It is instantiated once and registered in CLIP.

## Test plan
- Unsynced: x0=10, y0=20, w=3, h=2, colour 0xF0A.
  - Writes (20,10), (20,11), (20,12), (21,10), (21,11), (21,12) in T+2..T+7, all with data 0xF0A.
  - done in T+8, cmd_ready=1 in T+8.
- Clipping: x0=638, y0=479, w=5, h=3.
  - Exactly two writes: (479,638), (479,639).
  - done in the cycle after the second write.
- Empty commands: w=0; then x0=700, w=4, h=4.
  - Each gives zero writes, with done in T+2.
- Sync: cmd_sync=1 with vs held high for 1000 cycles.
  - No writes and busy=1 throughout.
  - vs then drops, with the edge detected in cycle V: first write in V+1.
  - A VS falling edge pulsed while in IDLE does not pre-arm the next command.
- Reset mid-fill: a 100x1 fill with rst asserted after 3 writes.
  - wrn=1 immediately.
  - After release: IDLE and cmd_ready=1, with no further writes and no done.
- Back-to-back: cmd_valid held high, command fields changed during FILL.
  - cmd_ready=0 while busy.
  - The second command is accepted in the done cycle and executed with the values present at that cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer geometry and pixel-RAM writer state encoding.
// Used by the scan controller and the rectangle fill engine.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 10;
    localparam int PIX_W    = 12;

    typedef enum logic [1:0] {
        IDLE,
        CLIP,
        WAIT_VS,
        FILL
    } fill_state_t;

endpackage

// File: rtl/vram_rect_fill_if.sv
// Fill command handshake plus pixel RAM write port.
// master = command source / RAM side, slave = fill engine.
interface vram_rect_fill_if;
    import vga_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [COL_W-1:0] cmd_x0;
    logic [ROW_W-1:0] cmd_y0;
    logic [COL_W-1:0] cmd_w;
    logic [ROW_W-1:0] cmd_h;
    logic [PIX_W-1:0] cmd_color;
    logic             cmd_sync;

    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [PIX_W-1:0] wr_data;
    logic             wrn;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h,
        output cmd_color, cmd_sync,
        input  cmd_ready, wr_row, wr_col, wr_data, wrn
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h,
        input  cmd_color, cmd_sync,
        output cmd_ready, wr_row, wr_col, wr_data, wrn
    );

endinterface

// File: rtl/vram_rect_clip.sv
// Combinational clip of a rectangle to the visible area.
// Produces inclusive end column/row and an empty flag.
module vram_rect_clip
    import vga_pkg::*;
(
    input  logic [COL_W-1:0] x0,
    input  logic [ROW_W-1:0] y0,
    input  logic [COL_W-1:0] w,
    input  logic [ROW_W-1:0] h,
    output logic [COL_W-1:0] xe,
    output logic [ROW_W-1:0] ye,
    output logic             empty
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [10:0] x_lim;
    logic [10:0] y_lim;
    logic [10:0] x_last;
    logic [10:0] y_last;

    always_comb begin
        x_end  = {1'b0, x0} + {1'b0, w};
        y_end  = {2'b0, y0} + {2'b0, h};
        x_lim  = (x_end > H_LIM) ? H_LIM : x_end;
        y_lim  = (y_end > V_LIM) ? V_LIM : y_end;
        x_last = x_lim - 11'd1;
        y_last = y_lim - 11'd1;
    end

    assign xe = x_last[COL_W-1:0];
    assign ye = y_last[ROW_W-1:0];

    assign empty = (w == '0) || (h == '0) ||
                   ({1'b0, x0} >= H_LIM) ||
                   ({2'b0, y0} >= V_LIM);

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: clips a command and writes it pixel by pixel,
// in raster order, into the framebuffer, optionally starting at VS.
module vram_rect_fill
    import vga_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            vs,
    vram_rect_fill_if.slave bus,
    output logic            busy,
    output logic            done
);

    fill_state_t      state;
    logic [COL_W-1:0] x0_q;
    logic [COL_W-1:0] w_q;
    logic [COL_W-1:0] xe_q;
    logic [ROW_W-1:0] y0_q;
    logic [ROW_W-1:0] h_q;
    logic [ROW_W-1:0] ye_q;
    logic [PIX_W-1:0] color_q;
    logic             sync_q;
    logic             vs_q;

    logic [COL_W-1:0] xe_c;
    logic [ROW_W-1:0] ye_c;
    logic             empty_c;
    logic             vs_fall;
    logic             start;
    logic             last_col;
    logic             last_row;

    vram_rect_clip u_clip (
        .x0    (x0_q),
        .y0    (y0_q),
        .w     (w_q),
        .h     (h_q),
        .xe    (xe_c),
        .ye    (ye_c),
        .empty (empty_c)
    );

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign vs_fall       = vs_q & ~vs;
    assign last_col      = (bus.wr_col == xe_q);
    assign last_row      = (bus.wr_row == ye_q);

    // Outputs are registered, so the first write is issued one state early.
    assign start = ((state == CLIP) && !empty_c && !sync_q) ||
                   ((state == WAIT_VS) && vs_fall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x0_q        <= '0;
            w_q         <= '0;
            xe_q        <= '0;
            y0_q        <= '0;
            h_q         <= '0;
            ye_q        <= '0;
            color_q     <= '0;
            sync_q      <= 1'b0;
            vs_q        <= 1'b1;
            done        <= 1'b0;
            bus.wrn     <= 1'b1;
            bus.wr_row  <= '0;
            bus.wr_col  <= '0;
            bus.wr_data <= '0;
        end else begin
            vs_q <= vs;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        x0_q    <= bus.cmd_x0;
                        y0_q    <= bus.cmd_y0;
                        w_q     <= bus.cmd_w;
                        h_q     <= bus.cmd_h;
                        color_q <= bus.cmd_color;
                        sync_q  <= bus.cmd_sync;
                        state   <= CLIP;
                    end
                end
                CLIP: begin
                    xe_q <= xe_c;
                    ye_q <= ye_c;
                    if (empty_c) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (sync_q) begin
                        state <= WAIT_VS;
                    end else begin
                        state <= FILL;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) state <= FILL;
                end
                FILL: begin
                    if (last_col && last_row) begin
                        bus.wrn <= 1'b1;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else if (last_col) begin
                        bus.wr_col <= x0_q;
                        bus.wr_row <= bus.wr_row + 1'b1;
                    end else begin
                        bus.wr_col <= bus.wr_col + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (start) begin
                bus.wrn     <= 1'b0;
                bus.wr_row  <= y0_q;
                bus.wr_col  <= x0_q;
                bus.wr_data <= color_q;
            end
        end
    end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Bench for vram_rect_fill: directed and random fills compared
// against a per-pixel reference list built from the clip rules.
module tb_vram_rect_fill;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs  = 1'b1;
    logic busy;
    logic done;

    vram_rect_fill_if bus ();

    vram_rect_fill dut (
        .clk  (clk),
        .rst  (rst),
        .vs   (vs),
        .bus  (bus),
        .busy (busy),
        .done (done)
    );

    always #20 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
        int cyc;
    } wr_t;

    wr_t got_w[$];
    wr_t exp_w[$];
    int  got_d[$];
    int  exp_d[$];
    int  hs_q[$];

    int cyc = 0;
    int ncmp = 0;
    int nerr = 0;
    int rdy_bad = 0;
    int rdy_done_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wrn === 1'b0)
                got_w.push_back('{int'(bus.wr_row), int'(bus.wr_col),
                                  int'(bus.wr_data), cyc});
            if (done === 1'b1) begin
                got_d.push_back(cyc);
                if (bus.cmd_ready !== 1'b1) rdy_done_bad++;
            end
            if (bus.cmd_valid && bus.cmd_ready === 1'b1) hs_q.push_back(cyc);
            if (bus.cmd_ready !== !busy) rdy_bad++;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: every visible pixel of the rectangle, raster order.
    task automatic add_rect(int x0, int y0, int w, int h, int color, int base);
        int xl;
        int yl;
        int n;
        xl = (x0 + w < H_ACTIVE) ? x0 + w : H_ACTIVE;
        yl = (y0 + h < V_ACTIVE) ? y0 + h : V_ACTIVE;
        n = 0;
        for (int r = y0; r < yl; r++)
            for (int c = x0; c < xl; c++) begin
                exp_w.push_back('{r, c, color, base + n});
                n++;
            end
        exp_d.push_back(base + n);
    endtask

    task automatic compare(string tag);
        chk({tag, "_nwr"}, got_w.size(), exp_w.size());
        foreach (exp_w[i]) begin
            if (i < got_w.size()) begin
                chk({tag, "_row"}, got_w[i].row, exp_w[i].row);
                chk({tag, "_col"}, got_w[i].col, exp_w[i].col);
                chk({tag, "_data"}, got_w[i].data, exp_w[i].data);
                chk({tag, "_wcyc"}, got_w[i].cyc, exp_w[i].cyc);
            end
        end
        chk({tag, "_ndone"}, got_d.size(), exp_d.size());
        foreach (exp_d[i])
            if (i < got_d.size()) chk({tag, "_dcyc"}, got_d[i], exp_d[i]);
        got_w.delete();
        exp_w.delete();
        got_d.delete();
        exp_d.delete();
        hs_q.delete();
    endtask

    task automatic set_fields(int x0, int y0, int w, int h, int color, bit sync);
        bus.cmd_x0    = 10'(x0);
        bus.cmd_y0    = 9'(y0);
        bus.cmd_w     = 10'(w);
        bus.cmd_h     = 9'(h);
        bus.cmd_color = 12'(color);
        bus.cmd_sync  = sync;
    endtask

    task automatic scramble();
        set_fields($urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic issue(int x0, int y0, int w, int h, int color, bit sync);
        int n0;
        n0 = hs_q.size();
        set_fields(x0, y0, w, h, color, sync);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200 && hs_q.size() == n0; i++) tick();
        bus.cmd_valid = 1'b0;
        scramble();
        chk("handshake", hs_q.size(), n0 + 1);
    endtask

    task automatic wait_done(int k);
        for (int i = 0; i < 3000 && got_d.size() < k; i++) tick();
    endtask

    task automatic run_cmd(string tag, int x0, int y0, int w, int h, int color);
        issue(x0, y0, w, h, color, 1'b0);
        if (hs_q.size() > 0) add_rect(x0, y0, w, h, color, hs_q[0] + 2);
        wait_done(1);
        compare(tag);
    endtask

    task automatic run_sync(string tag, int x0, int y0, int w, int h,
                            int color, int hold);
        int busy_low;
        int v;
        busy_low = 0;
        issue(x0, y0, w, h, color, 1'b1);
        for (int i = 0; i < hold; i++) begin
            tick();
            if (busy !== 1'b1) busy_low++;
        end
        chk({tag, "_busy"}, busy_low, 0);
        chk({tag, "_early"}, got_w.size(), 0);
        vs = 1'b0;
        v = cyc;
        add_rect(x0, y0, w, h, color, v + 1);
        tick();
        tick();
        vs = 1'b1;
        wait_done(1);
        compare(tag);
    endtask

    initial begin
        bus.cmd_valid = 1'b1;
        scramble();

        // Reset: outputs idle and no command accepted while rst is high.
        tick();
        tick();
        tick();
        chk("rst_wrn", bus.wrn, 1);
        chk("rst_row", bus.wr_row, 0);
        chk("rst_col", bus.wr_col, 0);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_busy", busy, 0);
        compare("post_rst");

        run_cmd("basic", 10, 20, 3, 2, 'hF0A);
        run_cmd("clip", 638, 479, 5, 3, 'h3C5);
        run_cmd("empty_w", 5, 5, 0, 4, 'h111);
        run_cmd("empty_x", 700, 10, 4, 4, 'h222);
        run_cmd("empty_y", 10, 500, 4, 4, 'h333);
        run_cmd("one_px", 639, 0, 1, 1, 'hABC);
        run_cmd("corner", 635, 476, 900, 300, 'h777);

        for (int k = 0; k < 20; k++)
            run_cmd("rand", $urandom_range(0, 700), $urandom_range(0, 510),
                    $urandom_range(0, 12), $urandom_range(0, 5),
                    $urandom_range(0, 4095));

        run_sync("sync", 100, 200, 5, 3, 'h0F0, 1000);

        // A VS edge seen in IDLE must not arm the next synced command.
        tick();
        vs = 1'b0;
        tick();
        tick();
        vs = 1'b1;
        tick();
        tick();
        run_sync("sync_noarm", 7, 9, 2, 2, 'h5A5, 50);

        // Reset in the middle of a fill.
        issue(0, 0, 100, 1, 'h5A5, 1'b0);
        for (int i = 0; i < 50 && got_w.size() < 3; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_wrn", bus.wrn, 1);
        chk("midrst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("midrst_nwr", got_w.size(), 3);
        chk("midrst_ndone", got_d.size(), 0);
        chk("midrst_ready", bus.cmd_ready, 1);
        got_w.delete();
        got_d.delete();
        hs_q.delete();

        // Back-to-back: valid held, fields changed while the first fills.
        set_fields(5, 6, 4, 2, 'h123, 1'b0);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 200 && hs_q.size() < 1; i++) tick();
        set_fields(30, 40, 2, 2, 'h456, 1'b0);
        for (int i = 0; i < 200 && hs_q.size() < 2; i++) tick();
        bus.cmd_valid = 1'b0;
        scramble();
        chk("b2b_nhs", hs_q.size(), 2);
        if (hs_q.size() >= 2) begin
            add_rect(5, 6, 4, 2, 'h123, hs_q[0] + 2);
            add_rect(30, 40, 2, 2, 'h456, hs_q[1] + 2);
            wait_done(2);
            if (got_d.size() > 0) chk("b2b_accept", hs_q[1], got_d[0]);
        end
        compare("b2b");

        chk("ready_decode", rdy_bad, 0);
        chk("ready_at_done", rdy_done_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
